ring_ni_tx: RTL
===============

# ring_ni_tx

Transmit-side network interface for one ring node. It accepts words from the local core over a valid/ready handshake and buffers them in a small FIFO. It then packetizes them into a header flit followed by body flits, and drives the router's local input port (`local_inN` of the ring) under credit-based flow control. One instance sits directly upstream of each router's local input.

## Interface
- `DATAWID`, 8: flit and data width; must match the ring.
- `NODE_ID`, 0: this node's ring index (0..11), placed in the header.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, minimum 2.
- `CREDITS`, 4: router local-input buffer slots; initial credit count.
- `clk` input 1: single clock; everything is updated on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `core_valid` input 1: core word valid.
- `core_ready` output 1: NI can accept a word.
- `core_data` input DATAWID: payload word.
- `core_dest` input 4: destination node. It is sampled only with the first word of a packet.
- `core_last` input 1: marks the final word of a packet.
- `flit_out` output DATAWID: flit to the router local input.
- `flit_write` output 1: one-cycle strobe; `flit_out` is valid while it is high.
- `flit_tail` output 1: high with the last body flit of a packet.
- `credit_ret` input 1: one-cycle pulse; the router has freed one local-input slot.
- `err_credit` output 1: sticky; set when a credit is returned while the counter is already at CREDITS.

## Operation
- **FIFO entry format:** {dest[3:0], last, data[DATAWID-1:0]}.
  - A push occurs on `core_valid & core_ready`.
  - `core_ready` = FIFO not full. It is computed from the registered occupancy only, with no combinational path from the pop side.
- **First-word tracking:** the `core_dest` stored in an entry is meaningful only for the first word of a packet. That is the first push after reset or after a push with `last`=1. A 1-bit `first` flag tracks this on the push side.
- **Header flit:** {dest[3:0], NODE_ID[3:0]} when DATAWID=8. For DATAWID>8 the upper bits are zero.
- **Body flits:** raw `data`, one per FIFO entry.
- **FSM states:**
  - IDLE: if the FIFO is not empty and credits > 0, emit the header using the head entry's dest, decrement credits, and go to BODY. The FIFO is not popped.
  - BODY: if the FIFO is not empty and credits > 0, emit the head entry's data, pop it, and decrement credits. If the entry has `last`=1, assert `flit_tail` and go to IDLE; otherwise stay in BODY. If the FIFO is empty or credits = 0, stall in BODY with `flit_write` low.
- **Credit counter:** width clog2(CREDITS+1).
  - Emit without return: −1.
  - Return without emit: +1.
  - Both in the same cycle: unchanged.
  - Return while at CREDITS and not emitting: the count is held at CREDITS and `err_credit` is set. It stays set until `rst`.
  - The counter never goes below 0. Emission is gated by credits > 0 as seen at the start of the cycle; a same-cycle return does not enable an emission.
- **FIFO push and pop:** push and pop in the same cycle are both legal. Occupancy is unchanged and the FIFO wraps modulo FIFO_DEPTH.
- **Reset:**
  - State: FSM=IDLE, FIFO empty, pointers 0, credits=CREDITS, `first`=1.
  - Outputs: `flit_out`=0, `flit_write`=0, `flit_tail`=0, `err_credit`=0, `core_ready`=1 from the cycle after `rst` is sampled.
  - `rst` asserted mid-packet discards the partial packet and all buffered words. No further flits are emitted.

## Timing
- `flit_out`, `flit_write` and `flit_tail` are registered outputs.
- A word pushed at edge t is visible in the FIFO at t+1. The header is registered at edge t+1, so `flit_write` is high in the cycle after edge t+1.
- The first body flit follows one cycle after the header.
- Sustained rate is one flit per cycle while credits and data are available. Packet overhead is one header cycle.
- `flit_write` is never high for two flits of the same FIFO entry. `flit_out` holds its last value when `flit_write` is low.
- A `credit_ret` sampled at edge t can enable an emission registered at edge t+1.

## Test plan
- **Reset values:** hold `rst` high for 2 cycles, then release. Required: `core_ready`=1, `flit_write`=0, `err_credit`=0, and the internal credit count is 4.
- **Single-word packet:** NODE_ID=3. Push data 0xA5, dest=7, last=1. Required: header 0x73, then body 0xA5 with `flit_tail`=1 on the next cycle, and credits=2.
- **Credit stall:** with no `credit_ret`, push a 6-word packet. Required:
  - Exactly 4 flits (header plus 3 bodies), then `flit_write` low.
  - After one `credit_ret` pulse, exactly one more flit, which is body word 4.
- **Back-pressure and wrap:** FIFO_DEPTH=4, credits=0, push 4 words. Required: `core_ready`=0, and the 5th word is not accepted.
  - Then pulse `credit_ret` each cycle. Required: words come out in order across the pointer wrap, and `core_ready` rises the cycle after the first pop.
- **Simultaneous emit and return:** at credits=1, pulse `credit_ret` in a cycle that emits a flit. Required: credits stays 1. Then return at credits=4 while idle. Required: count stays 4 and `err_credit`=1.
- **Reset mid-packet:** push 3 words of a 5-word packet, then assert `rst` after the header and the first body flit. Required: no further `flit_write`.
  - After release, a new packet with dest=2 yields header 0x23 (NODE_ID=3).

Source files
------------

// File: rtl/ring_ni_tx_if.sv
// Core-to-NI word handshake plus NI-to-router flit/credit signals for one ring node.
// The slave view is the NI; the master view is the core/router environment.
interface ring_ni_tx_if #(
  parameter int DATAWID = 8
) ();
  logic               core_valid;
  logic               core_ready;
  logic [DATAWID-1:0] core_data;
  logic [3:0]         core_dest;
  logic               core_last;
  logic [DATAWID-1:0] flit_out;
  logic               flit_write;
  logic               flit_tail;
  logic               credit_ret;

  modport master (
    output core_valid, core_data, core_dest, core_last, credit_ret,
    input  core_ready, flit_out, flit_write, flit_tail
  );

  modport slave (
    input  core_valid, core_data, core_dest, core_last, credit_ret,
    output core_ready, flit_out, flit_write, flit_tail
  );
endinterface

// File: rtl/ring_ni_tx.sv
// Ring node transmit NI: buffers core words in a small FIFO and emits header + body
// flits to the router local input under credit-based flow control.
//
// state | meaning
// IDLE  | between packets; next emission is the header built from the head entry's dest
// BODY  | header sent; each emission pops one entry, tail entry returns to IDLE
module ring_ni_tx #(
  parameter int DATAWID    = 8,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  ring_ni_tx_if.slave bus,
  output logic        err_credit
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int EW = DATAWID + 5;
  localparam logic [AW:0]    FULL     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [3:0]     NODE4    = 4'(NODE_ID);

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               first;
  logic [3:0]         pkt_dest;
  logic [CW-1:0]      credits;

  logic               core_ready;
  logic               push, pop, emit, can_emit, fifo_empty;
  logic [3:0]         push_dest;
  logic [EW-1:0]      head;
  logic [3:0]         head_dest;
  logic               head_last;
  logic [DATAWID-1:0] head_data;
  logic [DATAWID-1:0] hdr;
  logic [DATAWID-1:0] flit_nx;
  logic               tail_nx;

  logic [DATAWID-1:0] flit_q;
  logic               write_q, tail_q;

  // Ready depends only on registered occupancy, so no pop-side path reaches the core.
  assign core_ready     = (count != FULL);
  assign bus.core_ready = core_ready;
  assign push           = bus.core_valid & core_ready;
  assign fifo_empty     = (count == '0);
  assign can_emit       = !fifo_empty && (credits != '0);

  // Non-first words inherit the dest captured with the packet's first word.
  assign push_dest = first ? bus.core_dest : pkt_dest;

  assign head      = mem[rd_ptr];
  assign head_dest = head[EW-1 -: 4];
  assign head_last = head[DATAWID];
  assign head_data = head[DATAWID-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_dest, bus.core_last, bus.core_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      first    <= 1'b1;
      pkt_dest <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        first  <= bus.core_last;
        if (first) begin
          pkt_dest <= bus.core_dest;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (can_emit) state_nx = BODY;
      BODY:    if (can_emit && head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hdr      = '0;
    hdr[7:0] = {head_dest, NODE4};
    emit     = 1'b0;
    pop      = 1'b0;
    tail_nx  = 1'b0;
    flit_nx  = hdr;
    case (state)
      IDLE: begin
        emit = can_emit;
      end
      BODY: begin
        emit    = can_emit;
        pop     = can_emit;
        tail_nx = can_emit & head_last;
        flit_nx = head_data;
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  // flit_out keeps its last value between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q  <= '0;
      write_q <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      write_q <= emit;
      tail_q  <= tail_nx;
      if (emit) begin
        flit_q <= flit_nx;
      end
    end
  end

  // A return at full count is a router protocol error; the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CRED_MAX;
      err_credit <= 1'b0;
    end else begin
      case ({emit, bus.credit_ret})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CRED_MAX) begin
            err_credit <= 1'b1;
          end else begin
            credits <= credits + CW'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  assign bus.flit_out   = flit_q;
  assign bus.flit_write = write_q;
  assign bus.flit_tail  = tail_q;

endmodule
